button_debounce: RTL and testbench

//  Conditions one raw push-button pin for the edge-detector stage directly downstream.
//  - Synchronises the asynchronous pin into clk.
//  - Drives btn_out only after the pin holds a new level for STABLE_CYCLES clocks.
//  - Keeps a clean, idle-high level, so the downstream edge detector sees exactly one transition per press.

---
 rtl/button_debounce_pkg.sv | 20 ++
 rtl/button_debounce_sync_chain.sv | 30 +++
 rtl/button_debounce.sv | 132 +++++++++++++
 tb/tb_button_debounce.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared definitions for the push-button debouncer
// Purpose: state encodings, default qualification time and a saturating
//          counter helper shared by button_debounce and its bench.
// Ports:   none (package).
package button_debounce_pkg;

  // 2-bit FSM state encodings
  localparam logic [1:0] S_HIGH      = 2'b00;
  localparam logic [1:0] S_WAIT_LOW  = 2'b01;
  localparam logic [1:0] S_LOW       = 2'b10;
  localparam logic [1:0] S_WAIT_HIGH = 2'b11;

  // 10 ms at 50 MHz
  localparam int unsigned DB_STABLE_CYCLES_50MHZ = 500000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage

// File: rtl/button_debounce_sync_chain.sv
// rtl/button_debounce_sync_chain.sv - multi-flop synchroniser for the raw pin
// Purpose: brings an asynchronous input into the clk domain.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset, loads RESET_LEVEL into every stage
//   d    in  asynchronous input
//   q    out synchronised output (last stage)
module sync_chain #(
  parameter int   STAGES      = 2,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{RESET_LEVEL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - debounced, idle-high level for one push button
// Purpose: synchronises the raw pin and only commits a new output level after
//          the synchronised pin has held it for STABLE_CYCLES clocks.
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   btn_raw    in   asynchronous raw pin
//   btn_out    out  debounced level
//   busy       out  1 while a candidate level is being qualified
//   bounce_cnt out  saturating count of aborted qualifications
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_50MHZ,
  parameter int          SYNC_STAGES   = 2,
  parameter logic        RESET_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_out,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RST_STATE = RESET_LEVEL ? S_HIGH : S_LOW;

  logic             s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             busy_q, busy_d;
  logic [7:0]       bounce_q, bounce_d;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    btn_d    = btn_q;
    busy_d   = busy_q;
    bounce_d = bounce_q;
    case (state_q)
      S_HIGH: begin
        if (!s) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_WAIT_LOW: begin
        if (!s) begin
          if (cnt_q == CNT_MAX) begin
            state_d = S_LOW;
            btn_d   = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // any reversal restarts qualification from scratch
          state_d  = S_HIGH;
          cnt_d    = '0;
          busy_d   = 1'b0;
          bounce_d = sat_inc8(bounce_q);
        end
      end
      S_LOW: begin
        if (s) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (s) begin
          if (cnt_q == CNT_MAX) begin
            state_d = S_HIGH;
            btn_d   = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d  = S_LOW;
          cnt_d    = '0;
          busy_d   = 1'b0;
          bounce_d = sat_inc8(bounce_q);
        end
      end
      default: begin
        state_d = RST_STATE;
        btn_d   = RESET_LEVEL;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      btn_q    <= RESET_LEVEL;
      busy_q   <= 1'b0;
      bounce_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_q    <= btn_d;
      busy_q   <= busy_d;
      bounce_q <= bounce_d;
    end
  end

  assign btn_out    = btn_q;
  assign busy       = busy_q;
  assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b1;
  logic       btn_out;
  logic       busy;
  logic [7:0] bounce_cnt;

  int checks = 0;
  int errors = 0;

  button_debounce #(
    .STABLE_CYCLES (4),
    .SYNC_STAGES   (2),
    .RESET_LEVEL   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_out    (btn_out),
    .busy       (busy),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  // advance n posedges, landing 1 time unit after the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    btn_raw = 1'b1;
    tick(3);
    checks++;
    if (btn_out !== 1'b1) begin errors++; $display("FAIL reset_btn_out got %b want 1", btn_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (bounce_cnt !== 8'd0) begin errors++; $display("FAIL reset_bounce got %0d want 0", bounce_cnt); end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (btn_out !== 1'b1 || busy !== 1'b0 || bounce_cnt !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_after_reset bad_cycles %0d want 0", bad); end
  endtask

  task automatic test_press();
    btn_raw = 1'b0;
    tick(2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL press_busy_t2 got %b want 0", busy); end
    tick(1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL press_busy_t3 got %b want 1", busy); end
    tick(3);
    checks++;
    if (btn_out !== 1'b1) begin errors++; $display("FAIL press_btn_t6 got %b want 1", btn_out); end
    tick(1);
    checks++;
    if (btn_out !== 1'b0) begin errors++; $display("FAIL press_btn_t7 got %b want 0", btn_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL press_busy_t7 got %b want 0", busy); end
  endtask

  task automatic test_bounce();
    logic pat [7];
    int   bad;
    int   changes;
    logic prev;
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; btn_raw = 1'b1; tick(3); rst = 1'b0; tick(3);
    bad = 0; changes = 0; prev = btn_out;
    for (int i = 0; i < 7; i++) begin
      btn_raw = pat[i];
      tick(1);
      if (btn_out !== 1'b1) bad++;
      if (btn_out !== prev) changes++;
      prev = btn_out;
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (btn_out !== 1'b1) bad++;
      if (btn_out !== prev) changes++;
      prev = btn_out;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bounce_early_commit bad_cycles %0d want 0", bad); end
    tick(1);
    checks++;
    if (btn_out !== 1'b0) begin errors++; $display("FAIL bounce_commit got %b want 0", btn_out); end
    if (btn_out !== prev) changes++;
    prev = btn_out;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (btn_out !== prev) changes++;
      prev = btn_out;
    end
    checks++;
    if (changes != 1) begin errors++; $display("FAIL bounce_one_edge got %0d want 1", changes); end
    checks++;
    if (bounce_cnt !== 8'd2) begin errors++; $display("FAIL bounce_count got %0d want 2", bounce_cnt); end
  endtask

  task automatic test_release_glitch();
    int bad;
    bad = 0;
    btn_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (btn_out !== 1'b0) bad++;
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (btn_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL release_glitch_held bad_cycles %0d want 0", bad); end
    checks++;
    if (bounce_cnt !== 8'd3) begin errors++; $display("FAIL release_glitch_count got %0d want 3", bounce_cnt); end
    btn_raw = 1'b1;
    tick(6);
    checks++;
    if (btn_out !== 1'b0) begin errors++; $display("FAIL release_t6 got %b want 0", btn_out); end
    tick(1);
    checks++;
    if (btn_out !== 1'b1) begin errors++; $display("FAIL release_t7 got %b want 1", btn_out); end
    tick(3);
  endtask

  task automatic test_reset_mid_wait();
    btn_raw = 1'b0;
    tick(5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy_pre got %b want 1", busy); end
    rst = 1'b1;
    tick(1);
    checks++;
    if (btn_out !== 1'b1) begin errors++; $display("FAIL midwait_rst_btn got %b want 1", btn_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midwait_rst_busy got %b want 0", busy); end
    checks++;
    if (bounce_cnt !== 8'd0) begin errors++; $display("FAIL midwait_rst_bounce got %0d want 0", bounce_cnt); end
    rst = 1'b0;
    tick(6);
    checks++;
    if (btn_out !== 1'b1) begin errors++; $display("FAIL midwait_after_t6 got %b want 1", btn_out); end
    tick(1);
    checks++;
    if (btn_out !== 1'b0) begin errors++; $display("FAIL midwait_after_t7 got %b want 0", btn_out); end
    checks++;
    if (bounce_cnt !== 8'd0) begin errors++; $display("FAIL midwait_no_bounce got %0d want 0", bounce_cnt); end
  endtask

  task automatic test_saturation();
    int bad;
    rst = 1'b1; btn_raw = 1'b1; tick(3); rst = 1'b0; tick(3);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      btn_raw = 1'b0;
      tick(1);
      if (btn_out !== 1'b1) bad++;
      btn_raw = 1'b1;
      tick(1);
      if (btn_out !== 1'b1) bad++;
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (btn_out !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sat_btn_held bad_cycles %0d want 0", bad); end
    checks++;
    if (bounce_cnt !== 8'd255) begin errors++; $display("FAIL sat_count got %0d want 255", bounce_cnt); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release_glitch();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
